// File: rtl/serial_rx_v2_if.sv
// Link-side and word-side signals of the serial receiver.
// master = receiver, slave = link driver / word consumer.
`timescale 1ns/1ps
interface serial_rx_v2_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SERIAL_MODE = 2,
    parameter int CMD_NUM_WID = 6
);
    logic                   RX_CLK;
    logic [SERIAL_MODE-1:0] RX_DIN;
    logic                   rx_valid_o;
    logic [DATA_WIDTH-1:0]  rx_data_o;
    logic                   rx_done_o;
    logic [CMD_NUM_WID-1:0] rx_len_o;
    logic                   rx_crc_err_o;
    logic                   rx_frame_err_o;
    logic                   rx_busy_o;

    modport master (
        input  RX_CLK, RX_DIN,
        output rx_valid_o, rx_data_o, rx_done_o, rx_len_o,
        output rx_crc_err_o, rx_frame_err_o, rx_busy_o
    );

    modport slave (
        output RX_CLK, RX_DIN,
        input  rx_valid_o, rx_data_o, rx_done_o, rx_len_o,
        input  rx_crc_err_o, rx_frame_err_o, rx_busy_o
    );
endinterface

// File: rtl/serial_rx_v2.sv
// Source-synchronous serial link receiver: deserialises clock bursts into words,
// treats the final word of each burst as CRC32 over the preceding data words.
`timescale 1ns/1ps
module serial_rx_v2 #(
    parameter real TCQ         = 0.1,
    parameter int  DATA_WIDTH  = 32,
    parameter int  SERIAL_MODE = 2,
    parameter int  CMD_NUM_WID = 6,
    parameter int  IDLE_GAP    = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    serial_rx_v2_if.master  bus
);
    localparam int SERIAL_NUM = DATA_WIDTH / SERIAL_MODE;
    localparam int NBYTES     = DATA_WIDTH / 8;
    localparam int BCNT_W     = (SERIAL_NUM > 1) ? $clog2(SERIAL_NUM) : 1;
    localparam int GAP_W      = $clog2(IDLE_GAP + 1);
    localparam int SCNT_W     = $clog2(NBYTES + 1);

    localparam logic [BCNT_W-1:0]      BCNT_LAST = BCNT_W'(SERIAL_NUM - 1);
    localparam logic [BCNT_W-1:0]      BCNT_ONE  = BCNT_W'(1);
    localparam logic [GAP_W-1:0]       GAP_END   = GAP_W'(IDLE_GAP);
    localparam logic [GAP_W-1:0]       GAP_ONE   = GAP_W'(1);
    localparam logic [SCNT_W-1:0]      SCNT_LOAD = SCNT_W'(NBYTES);
    localparam logic [SCNT_W-1:0]      SCNT_ONE  = SCNT_W'(1);
    localparam logic [CMD_NUM_WID:0]   WCNT_ONE  = 1;
    localparam logic [CMD_NUM_WID:0]   WCNT_MAX  = '1;
    localparam logic [CMD_NUM_WID:0]   WCNT_LIM  = {1'b1, {CMD_NUM_WID{1'b0}}};
    localparam logic [31:0]            CRC_POLY  = 32'h04C1_1DB7;

    if ((DATA_WIDTH % 8 != 0) || (DATA_WIDTH % SERIAL_MODE != 0) || (DATA_WIDTH < 32) ||
        !((SERIAL_MODE == 1) || (SERIAL_MODE == 2) || (SERIAL_MODE == 4) || (SERIAL_MODE == 8)) ||
        (IDLE_GAP < 8) || (SERIAL_NUM * 4 < NBYTES + 2) || (TCQ < 0.0)) begin : g_param_err
        $error("serial_rx_v2: unsupported parameter combination");
    end

    // One byte of the CRC32_D8 engine: MSB-first, polynomial 0x04C11DB7.
    function automatic logic [31:0] crc32_d8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_CHECK, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              clk_sync_p;
    logic [SERIAL_MODE-1:0]  din_p0, din_p1;
    logic [DATA_WIDTH-1:0]   sh_q, hold_q, ser_word_q, sh_nxt;
    logic [31:0]             crc_q;
    logic [BCNT_W-1:0]       bcnt_q;
    logic [GAP_W-1:0]        gcnt_q;
    logic [SCNT_W-1:0]       ser_cnt_q;
    logic [CMD_NUM_WID:0]    wcnt_q, wcnt_m1;
    logic                    armed_q, have_hold_q, ovf_q;
    logic                    clk_pose, take, word_done, emit, chk_go;
    logic                    rx_valid_q, rx_done_q, rx_crc_err_q, rx_frame_err_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic [CMD_NUM_WID-1:0]  rx_len_q;

    // Stage p0/p1: two-flop synchronisers keep clock and data aligned; third clock flop for edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) clk_sync_p <= '0;
        else       clk_sync_p <= {clk_sync_p[1:0], bus.RX_CLK};
    end

    always_ff @(posedge clk_i) begin
        din_p0 <= bus.RX_DIN;
        din_p1 <= din_p0;
    end

    assign clk_pose  = clk_sync_p[1] & ~clk_sync_p[2];
    assign take      = clk_pose && ((state_q == ST_RX) || ((state_q == ST_IDLE) && armed_q));
    assign word_done = take && (bcnt_q == BCNT_LAST);
    assign emit      = word_done && have_hold_q;
    assign sh_nxt    = {sh_q[DATA_WIDTH-SERIAL_MODE-1:0], din_p1};
    assign chk_go    = (state_q == ST_CHECK) && (ser_cnt_q == '0);
    assign wcnt_m1   = wcnt_q - WCNT_ONE;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clk_pose && armed_q)              state_d = ST_RX;
            ST_RX:    if (!clk_pose && (gcnt_q == GAP_END)) state_d = ST_CHECK;
            ST_CHECK: if (ser_cnt_q == '0)                  state_d = ST_DONE;
            default:                                        state_d = ST_IDLE;
        endcase
    end

    // Stage p2: word assembly, hold register and byte-serial CRC datapath.
    always_ff @(posedge clk_i) begin
        if (take)      sh_q   <= sh_nxt;
        if (word_done) hold_q <= sh_nxt;
        if (emit)                   ser_word_q <= hold_q;
        else if (ser_cnt_q != '0)   ser_word_q <= ser_word_q << 8;
        if (state_q == ST_IDLE)     crc_q <= '1;
        else if (ser_cnt_q != '0)   crc_q <= crc32_d8(crc_q, ser_word_q[DATA_WIDTH-1 -: 8]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gcnt_q         <= '0;
            bcnt_q         <= '0;
            armed_q        <= 1'b0;
            have_hold_q    <= 1'b0;
            wcnt_q         <= '0;
            ovf_q          <= 1'b0;
            ser_cnt_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            rx_done_q      <= 1'b0;
            rx_len_q       <= '0;
            rx_crc_err_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;

            // In IDLE the gap counter measures low link clock; in RX, cycles since the last edge.
            case (state_q)
                ST_IDLE: gcnt_q <= clk_sync_p[1] ? '0 : ((gcnt_q == GAP_END) ? gcnt_q : gcnt_q + GAP_ONE);
                ST_RX:   gcnt_q <= clk_pose      ? '0 : ((gcnt_q == GAP_END) ? gcnt_q : gcnt_q + GAP_ONE);
                default: gcnt_q <= '0;
            endcase

            if ((state_q == ST_IDLE) && (gcnt_q == GAP_END)) armed_q <= 1'b1;
            if (take && (state_q == ST_IDLE))                armed_q <= 1'b0;
            if (state_q == ST_DONE)                          armed_q <= 1'b1;

            if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
                have_hold_q <= 1'b0;
                wcnt_q      <= '0;
                ovf_q       <= 1'b0;
                bcnt_q      <= '0;
            end

            if (take)      bcnt_q      <= (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + BCNT_ONE;
            if (word_done) have_hold_q <= 1'b1;

            if (emit) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= hold_q;
                ser_cnt_q  <= SCNT_LOAD;
                if (wcnt_q != WCNT_MAX) wcnt_q <= wcnt_q + WCNT_ONE;
                if (wcnt_q == WCNT_LIM) ovf_q  <= 1'b1;
            end else if (ser_cnt_q != '0) begin
                ser_cnt_q <= ser_cnt_q - SCNT_ONE;
            end

            if (chk_go) begin
                rx_done_q      <= 1'b1;
                rx_len_q       <= wcnt_m1[CMD_NUM_WID-1:0];
                rx_frame_err_q <= (bcnt_q != '0) || (wcnt_q == '0) || ovf_q;
                rx_crc_err_q   <= (wcnt_q != '0) && (hold_q[31:0] != crc_q);
            end
        end
    end

    assign bus.rx_valid_o     = rx_valid_q;
    assign bus.rx_data_o      = rx_data_q;
    assign bus.rx_done_o      = rx_done_q;
    assign bus.rx_len_o       = rx_len_q;
    assign bus.rx_crc_err_o   = rx_crc_err_q;
    assign bus.rx_frame_err_o = rx_frame_err_q;
    assign bus.rx_busy_o      = (state_q != ST_IDLE);
endmodule
